// File: rtl/framebuffer_ctrl_pkg.sv
// Shared types and constants for the double-buffered framebuffer.
// Screen coordinates, bank addressing and controller states.
package framebuffer_ctrl_pkg;

    localparam int H_RES    = 320;
    localparam int V_RES    = 240;
    localparam int FB_DEPTH = H_RES * V_RES;

    typedef logic [16:0] fb_addr_t;
    typedef logic [2:0]  color_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } screenXY;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ACK,
        S_RENDER,
        S_WAIT_VBLANK,
        S_SWAP
    } fb_state_t;

    // y*320 + x without a multiplier
    function automatic fb_addr_t xy_addr(logic [8:0] x, logic [7:0] y);
        fb_addr_t yy;
        yy = fb_addr_t'(y);
        return (yy << 8) + (yy << 6) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/framebuffer_ctrl_if.sv
// Renderer-side port bundle: pixel writes plus the frame handshake.
interface framebuffer_ctrl_if;
    import framebuffer_ctrl_pkg::*;

    logic    pix_we;
    screenXY pix_coords;
    color_t  pix_color;
    logic    render_done;
    logic    render_ack;

    modport master (
        output pix_we,
        output pix_coords,
        output pix_color,
        output render_done,
        input  render_ack
    );

    modport slave (
        input  pix_we,
        input  pix_coords,
        input  pix_color,
        input  render_done,
        output render_ack
    );

endinterface

// File: rtl/framebuffer_ctrl_fb_bank_ram.sv
// One framebuffer bank: single write port, registered read port.
module fb_bank_ram
    import framebuffer_ctrl_pkg::*;
#(
    parameter int DEPTH = framebuffer_ctrl_pkg::FB_DEPTH
) (
    input  logic     clk,
    input  logic     we,
    input  fb_addr_t waddr,
    input  color_t   wdata,
    input  fb_addr_t raddr,
    output color_t   rdata
);

    color_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/framebuffer_ctrl.sv
// Double-buffered framebuffer: renderer fills the back bank, VGA scans
// the front bank, banks swap on vblank and the new back bank is cleared.
module framebuffer_ctrl
    import framebuffer_ctrl_pkg::*;
#(
    parameter int           H_RES    = framebuffer_ctrl_pkg::H_RES,
    parameter int           V_RES    = framebuffer_ctrl_pkg::V_RES,
    parameter logic [2:0]   BG_COLOR = 3'b000
) (
    input  logic                Clk,
    input  logic                Reset,
    framebuffer_ctrl_if.slave   ren,
    input  logic                vblank,
    input  logic [9:0]          vga_x,
    input  logic [9:0]          vga_y,
    output color_t              vga_color,
    output logic                drop_flag
);

    localparam int       DEPTH = H_RES * V_RES;
    localparam fb_addr_t LAST  = fb_addr_t'(DEPTH - 1);

    fb_state_t state;
    fb_state_t state_nx;
    fb_addr_t  clr_addr;
    logic      front;
    logic      shown_valid;
    logic      ack;

    logic      in_range;
    logic      pix_ok;
    logic      we;
    fb_addr_t  waddr;
    color_t    wdata;

    logic      vis;
    fb_addr_t  raddr;
    logic      vis_q;
    logic      sel_q;
    color_t    rd0;
    color_t    rd1;

    assign in_range = (int'(ren.pix_coords.x) < H_RES)
                   && (int'(ren.pix_coords.y) < V_RES);
    assign pix_ok   = (state == S_RENDER) && ren.pix_we && in_range;

    always_comb begin
        state_nx = state;
        ack      = 1'b0;
        unique case (state)
            S_CLEAR:       if (clr_addr == LAST) state_nx = S_ACK;
            S_ACK: begin
                ack      = 1'b1;
                state_nx = S_RENDER;
            end
            S_RENDER:      if (ren.render_done) state_nx = S_WAIT_VBLANK;
            S_WAIT_VBLANK: if (vblank) state_nx = S_SWAP;
            S_SWAP:        state_nx = S_CLEAR;
            default:       state_nx = S_CLEAR;
        endcase
    end

    assign ren.render_ack = ack;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_CLEAR;
            clr_addr    <= '0;
            front       <= 1'b0;
            shown_valid <= 1'b0;
            drop_flag   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR) begin
                clr_addr <= (clr_addr == LAST) ? '0
                                               : clr_addr + fb_addr_t'(1);
            end
            if (state == S_SWAP) begin
                front       <= ~front;
                shown_valid <= 1'b1;
            end
            if (ren.pix_we && !pix_ok) begin
                drop_flag <= 1'b1;
            end
        end
    end

    // Back-bank write port: clear counter in CLEAR, renderer in RENDER
    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = BG_COLOR;
        if (state == S_CLEAR) begin
            we = 1'b1;
        end else if (pix_ok) begin
            we    = 1'b1;
            waddr = xy_addr(ren.pix_coords.x, ren.pix_coords.y);
            wdata = ren.pix_color;
        end
    end

    assign vis   = (vga_x < 10'(H_RES)) && (vga_y < 10'(V_RES));
    assign raddr = vis ? xy_addr(vga_x[8:0], vga_y[7:0]) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vis_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            vis_q <= vis && shown_valid;
            sel_q <= front;
        end
    end

    fb_bank_ram #(.DEPTH(DEPTH)) u_bank0 (
        .clk   (Clk),
        .we    (we && front),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rd0)
    );

    fb_bank_ram #(.DEPTH(DEPTH)) u_bank1 (
        .clk   (Clk),
        .we    (we && !front),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rd1)
    );

    assign vga_color = vis_q ? (sel_q ? rd1 : rd0) : BG_COLOR;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// Scoreboard bench for framebuffer_ctrl with a reduced screen height
// so several full frame turnarounds fit in a short run.
module tb_framebuffer_ctrl;
    import framebuffer_ctrl_pkg::*;

    localparam int         HR    = 320;
    localparam int         VR    = 16;
    localparam int         DEPTH = HR * VR;
    localparam logic [2:0] BG    = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblank = 1'b0;
    logic [9:0] vga_x = '0;
    logic [9:0] vga_y = '0;
    color_t     vga_color;
    logic       drop_flag;

    framebuffer_ctrl_if ren_if ();

    framebuffer_ctrl #(
        .H_RES    (HR),
        .V_RES    (VR),
        .BG_COLOR (BG)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .ren       (ren_if),
        .vblank    (vblank),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .drop_flag (drop_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [2:0] c;
        string      name;
    } rd_t;

    rd_t rdq [$];
    int  ackq [$];
    int  checks = 0;
    int  errors = 0;
    int  ack_seen = 0;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: ack edge and delayed scan-out reads
    always @(negedge clk) begin
        rd_t r;
        if (ren_if.render_ack) begin
            ack_seen++;
            if (ackq.size() == 0) chk("unexpected_ack", cyc + 1, -1);
            else chk("ack_cycle", cyc + 1, ackq.pop_front());
        end
        while (rdq.size() > 0 && rdq[0].due <= cyc) begin
            r = rdq.pop_front();
            chk(r.name, int'(vga_color), int'(r.c));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(int x, int y, logic [2:0] exp, string name);
        vga_x = 10'(x);
        vga_y = 10'(y);
        rdq.push_back('{cyc + 1, exp, name});
        tick();
    endtask

    task automatic pix(int x, int y, logic [2:0] c);
        ren_if.pix_we       = 1'b1;
        ren_if.pix_coords.x = 9'(x);
        ren_if.pix_coords.y = 8'(y);
        ren_if.pix_color    = c;
        tick();
        ren_if.pix_we = 1'b0;
    endtask

    task automatic done();
        ren_if.render_done = 1'b1;
        tick();
        ren_if.render_done = 1'b0;
    endtask

    task automatic vbl(bit expect_swap);
        if (expect_swap) ackq.push_back(cyc + 1 + DEPTH + 2);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
    endtask

    task automatic wait_ack();
        int start;
        int n;
        start = ack_seen;
        n = 0;
        while (ack_seen == start && n < DEPTH + 200) begin
            tick();
            n++;
        end
        chk("ack_arrived", int'(ack_seen != start), 1);
    endtask

    initial begin
        ren_if.pix_we      = 1'b0;
        ren_if.pix_coords  = '0;
        ren_if.pix_color   = '0;
        ren_if.render_done = 1'b0;
        repeat (3) tick();
        chk("rst_ack", int'(ren_if.render_ack), 0);
        chk("rst_drop", int'(drop_flag), 0);
        chk("rst_color", int'(vga_color), int'(BG));

        rst = 1'b0;
        ackq.push_back(cyc + DEPTH + 1);
        rd(0, 0, BG, "pre_swap_bg");
        wait_ack();

        chk("drop_idle", int'(drop_flag), 0);
        pix(5, 7, 3'b101);
        pix(319, 15, 3'b111);
        chk("drop_inrange", int'(drop_flag), 0);
        pix(320, 0, 3'b110);
        chk("drop_x_range", int'(drop_flag), 1);
        pix(0, 16, 3'b110);
        done();
        repeat (2) tick();
        vbl(1);
        repeat (3) tick();
        rd(5, 7, 3'b101, "f1_pixel");
        rd(6, 7, BG, "f1_neighbour_bg");
        rd(0, 1, BG, "f1_no_wrap");
        rd(319, 15, 3'b111, "f1_corner");
        rd(0, 0, BG, "f1_origin_bg");
        rd(320, 5, BG, "offscreen_x");
        rd(5, 16, BG, "offscreen_y");
        done();
        wait_ack();

        pix(5, 7, 3'b010);
        ren_if.render_done = 1'b1;
        vblank = 1'b1;
        tick();
        ren_if.render_done = 1'b0;
        vblank = 1'b0;
        repeat (4) tick();
        rd(5, 7, 3'b101, "same_cycle_no_swap");
        vbl(1);
        repeat (3) tick();
        rd(5, 7, 3'b010, "f2_pixel");
        rd(319, 15, BG, "f2_corner_bg");
        wait_ack();

        vbl(0);
        repeat (2) tick();
        rd(5, 7, 3'b010, "vblank_in_render");
        done();
        tick();
        vbl(1);
        repeat (3) tick();
        rd(5, 7, BG, "f3_cleared");
        rd(319, 15, BG, "f3_corner_cleared");
        wait_ack();

        done();
        tick();
        vbl(1);
        repeat (3) tick();
        pix(1, 1, 3'b011);
        chk("drop_outside_render", int'(drop_flag), 1);
        repeat (DEPTH / 2) tick();
        rst = 1'b1;
        ackq.delete();
        repeat (2) tick();
        chk("rst2_ack", int'(ren_if.render_ack), 0);
        chk("rst2_drop", int'(drop_flag), 0);
        chk("rst2_color", int'(vga_color), int'(BG));
        rst = 1'b0;
        ackq.push_back(cyc + DEPTH + 1);
        wait_ack();
        rd(5, 7, BG, "post_reset_bg");

        repeat (3) tick();
        chk("reads_drained", rdq.size(), 0);
        chk("acks_drained", ackq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
